// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 decryption types, FSM encoding, inverse S-box and inverse round helpers.
//   block_t : 129-bit block, [127:0] AES state, [128] pass-through tag
//   state_t : 128-bit AES state, byte 0 in bits [127:120], column-major
//   kidx_t  : round key index
package aes_pkg;

    localparam int AES_ROUNDS = 10;
    localparam int TAG_BIT    = 128;
    localparam int KEY_IDX_W  = 4;

    typedef logic [128:0]          block_t;
    typedef logic [127:0]          state_t;
    typedef logic [KEY_IDX_W-1:0]  kidx_t;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

    // Entry 0 sits in the top byte, so entry b lives at bit offset 8*(255-b) = {~b, 3'b000}.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // InvMixColumns row 0 coefficients {0e, 0b, 0d, 09}; later rows are rotations.
    localparam logic [15:0] INV_MIX_COEF = 16'hebd9;

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic state_t inv_sub_bytes(input state_t s);
        state_t o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4].
    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
        return o;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit GF(2^8) constant, enough for all InvMixColumns coefficients.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] m);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return (m[3] ? b8 : 8'h00) ^ (m[2] ? b4 : 8'h00) ^ (m[1] ? b2 : 8'h00) ^ (m[0] ? b : 8'h00);
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t o;
        logic [7:0] acc;
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc ^= gf_mul(s[127 - 8*(4*c + k) -: 8], INV_MIX_COEF[15 - 4*((k + 4 - j) % 4) -: 4]);
                o[127 - 8*(4*c + j) -: 8] = acc;
            end
        return o;
    endfunction

endpackage

// File: rtl/decryption_core_round.sv
// decryptionRound: combinational AES inverse round.
//   key    : round key XORed after InvSubBytes
//   data   : round input state
//   last   : final round, InvMixColumns skipped
//   result : round output state
module decryptionRound
    import aes_pkg::*;
(
    input  state_t key,
    input  state_t data,
    input  logic   last,
    output state_t result
);

    state_t added;

    always_comb begin
        added  = inv_sub_bytes(inv_shift_rows(data)) ^ key;
        result = last ? added : inv_mix_columns(added);
    end

endmodule

// File: rtl/decryption_core.sv
// decryption_core: iterative AES-128 decryption, one inverse round per clock.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : ciphertext handshake, data_in = {tag, ciphertext}
//   key_idx/round_key   : combinational round key lookup into external key storage
//   out_valid/out_ready : plaintext handshake, data_out = {tag, plaintext}, 0 when not valid
//   busy                : inverse rounds in progress
module decryption_core
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_ROUNDS,
    parameter int KIDX_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [128:0]      data_in,
    output logic [KIDX_W-1:0] key_idx,
    input  logic [127:0]      round_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [128:0]      data_out,
    output logic              busy
);

    fsm_t              state, state_nxt;
    logic [KIDX_W-1:0] cnt, cnt_nxt;
    block_t            data_q, data_nxt;
    state_t            round_res;
    logic              accept;

    // One round instance shared by every iteration; FINAL drops InvMixColumns.
    decryptionRound u_round (
        .key    (round_key),
        .data   (data_q[127:0]),
        .last   (state == FINAL),
        .result (round_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= KIDX_W'(NUM_ROUNDS - 1);
            data_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            data_q <= data_nxt;
        end
    end

    always_comb begin
        in_ready  = state == IDLE || (state == DONE && out_ready);
        accept    = in_valid && in_ready;
        out_valid = state == DONE;
        busy      = state == ROUND || state == FINAL;
        data_out  = out_valid ? data_q : '0;
        key_idx   = state == ROUND ? cnt : state == FINAL ? '0 : KIDX_W'(NUM_ROUNDS);
        state_nxt = state;
        cnt_nxt   = cnt;
        data_nxt  = data_q;
        // Accept is only possible in IDLE/DONE, where key_idx selects the last round key.
        if (accept) begin
            state_nxt = ROUND;
            cnt_nxt   = KIDX_W'(NUM_ROUNDS - 1);
            data_nxt  = {data_in[TAG_BIT], data_in[127:0] ^ round_key};
        end else begin
            case (state)
                ROUND: begin
                    data_nxt  = {data_q[TAG_BIT], round_res};
                    cnt_nxt   = cnt - 1'b1;
                    state_nxt = cnt == KIDX_W'(1) ? FINAL : ROUND;
                end
                FINAL: begin
                    data_nxt  = {data_q[TAG_BIT], round_res};
                    state_nxt = DONE;
                end
                DONE:    state_nxt = out_ready ? IDLE : DONE;
                default: state_nxt = state;
            endcase
        end
    end

endmodule

// File: tb/tb_decryption_core.sv
// tb_decryption_core: directed and random checks of decryption_core against a forward AES-128 model.
module tb_decryption_core;

    logic         clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic         in_ready, out_valid, busy;
    logic [128:0] data_in = '0, data_out;
    logic [3:0]   key_idx;
    logic [127:0] round_key, noise = '0;
    logic         noise_en = 0;
    logic [127:0] rk [11];
    logic [7:0]   sbox [256];
    int           n_vec = 0, n_err = 0;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;

    assign round_key = noise_en ? noise : rk[key_idx];

    decryption_core #(.NUM_ROUNDS(10), .KIDX_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .key_idx   (key_idx),
        .round_key (round_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [128:0] got, input logic [128:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] r;
        for (int x = 0; x < 256; x++) begin
            r = 8'h01;
            for (int k = 0; k < 254; k++) r = gm(r, 8'(x));
            sbox[x] = r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] p);
        logic [127:0] s, t;
        logic [7:0]   mc [4];
        logic [7:0]   acc;
        mc = '{8'h02, 8'h03, 8'h01, 8'h01};
        s = p ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[8*i +: 8] = sbox[s[8*i +: 8]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    s[127 - 8*(4*c + w) -: 8] = t[127 - 8*(4*((c + w) % 4) + w) -: 8];
            if (r < 10) begin
                for (int c = 0; c < 4; c++)
                    for (int j = 0; j < 4; j++) begin
                        acc = 8'h00;
                        for (int k = 0; k < 4; k++) acc ^= gm(s[127 - 8*(4*c + k) -: 8], mc[(k + 4 - j) % 4]);
                        t[127 - 8*(4*c + j) -: 8] = acc;
                    end
                s = t;
            end
            s ^= rk[r];
        end
        return s;
    endfunction

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            step();
            lat++;
        end
    endtask

    // Starts in IDLE with out_ready=1, ends back in IDLE.
    task automatic run_one(input string tag, input logic [127:0] key, input logic tg, input logic [127:0] p);
        logic [127:0] c;
        int lat;
        expand(key);
        c = encrypt(p);
        out_ready = 1;
        in_valid  = 1;
        data_in   = {tg, c};
        step();
        in_valid = 0;
        wait_out(lat);
        check({tag, "_lat"}, 129'(lat), 129'(10));
        check(tag, data_out, {tg, p});
        check({tag, "_reenc"}, 129'(encrypt(data_out[127:0])), 129'(c));
        step();
    endtask

    initial begin
        int lat;
        logic [127:0] k, pa, pb, ca, cb;
        logic tg;
        build_sbox();

        // reset state
        repeat (2) step();
        check("rst_out_valid", 129'(out_valid), 129'(0));
        check("rst_in_ready", 129'(in_ready), 129'(1));
        check("rst_busy", 129'(busy), 129'(0));
        check("rst_key_idx", 129'(key_idx), 129'(10));
        check("rst_data_out", data_out, 129'(0));
        rst = 0;
        step();

        // FIPS-197 C.1 with backpressure at the end
        expand(K1);
        out_ready = 0;
        in_valid  = 1;
        data_in   = {1'b1, C1};
        #1;
        check("c1_in_ready", 129'(in_ready), 129'(1));
        check("c1_kidx_idle", 129'(key_idx), 129'(10));
        step();
        in_valid = 0;
        for (int j = 0; j < 10; j++) begin
            check($sformatf("c1_kidx_%0d", j), 129'(key_idx), 129'(j < 9 ? 9 - j : 0));
            check($sformatf("c1_nvalid_%0d", j), 129'(out_valid), 129'(0));
            step();
        end
        check("c1_out_valid", 129'(out_valid), 129'(1));
        check("c1_data", data_out, {1'b1, P1});
        check("c1_kidx_done", 129'(key_idx), 129'(10));

        in_valid = 1;
        data_in  = {1'b0, C1};
        for (int j = 0; j < 5; j++) begin
            step();
            check("bp_data", data_out, {1'b1, P1});
            check("bp_in_ready", 129'(in_ready), 129'(0));
            check("bp_busy", 129'(busy), 129'(0));
            check("bp_out_valid", 129'(out_valid), 129'(1));
        end
        out_ready = 1;
        #1;
        check("bp_release_ready", 129'(in_ready), 129'(1));
        step();
        in_valid = 0;
        check("bp_accepted_busy", 129'(busy), 129'(1));
        wait_out(lat);
        check("bp_lat", 129'(lat), 129'(10));
        check("bp_data2", data_out, {1'b0, P1});
        step();
        check("bp_once_valid", 129'(out_valid), 129'(0));
        check("bp_once_busy", 129'(busy), 129'(0));
        check("bp_once_ready", 129'(in_ready), 129'(1));

        // back-to-back
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        pa = 128'h3243f6a8885a308d313198a2e0370734;
        pb = 128'hffeeddccbbaa99887766554433221100;
        ca = encrypt(pa);
        cb = encrypt(pb);
        in_valid = 1;
        data_in  = {1'b1, ca};
        step();
        in_valid = 0;
        wait_out(lat);
        check("b2b_a", data_out, {1'b1, pa});
        in_valid = 1;
        data_in  = {1'b0, cb};
        #1;
        check("b2b_in_ready", 129'(in_ready), 129'(1));
        step();
        in_valid = 0;
        wait_out(lat);
        check("b2b_gap", 129'(lat + 1), 129'(11));
        check("b2b_b", data_out, {1'b0, pb});
        step();

        // reset mid-run at counter 5
        expand(K1);
        in_valid = 1;
        data_in  = {1'b1, C1};
        step();
        in_valid = 0;
        lat = 0;
        while (key_idx != 4'd5 && lat < 20) begin
            step();
            lat++;
        end
        check("mid_busy", 129'(busy), 129'(1));
        check("mid_gated_data", data_out, 129'(0));
        rst = 1;
        #1;
        check("mid_rst_valid", 129'(out_valid), 129'(0));
        check("mid_rst_ready", 129'(in_ready), 129'(1));
        check("mid_rst_kidx", 129'(key_idx), 129'(10));
        check("mid_rst_busy", 129'(busy), 129'(0));
        step();
        rst = 0;
        step();
        run_one("after_rst", K1, 1'b1, P1);

        // idle noise on round_key
        noise_en = 1;
        for (int j = 0; j < 8; j++) begin
            noise = {$urandom, $urandom, $urandom, $urandom};
            step();
            check("noise_valid", 129'(out_valid), 129'(0));
            check("noise_busy", 129'(busy), 129'(0));
            check("noise_kidx", 129'(key_idx), 129'(10));
        end
        noise_en = 0;
        run_one("after_noise", K1, 1'b0, P1);

        // random regression
        for (int n = 0; n < 200; n++) begin
            k  = {$urandom, $urandom, $urandom, $urandom};
            pa = {$urandom, $urandom, $urandom, $urandom};
            tg = 1'($urandom);
            run_one("rand", k, tg, pa);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/decryption_core.md
Name: decryption_core

Overview:
Iterative AES-128 decryption engine, the inverse counterpart of the per-round encryption datapath. Takes one 129-bit block (128-bit ciphertext plus 1 pass-through tag bit) and runs one inverse round per clock. Round keys come from the shared key-schedule storage through a key index / round key lookup. Plaintext is returned through a valid/ready handshake. Sits between the ciphertext input buffer and the plaintext output path of the crypto module.

Parameters:
NUM_ROUNDS, 10, number of AES rounds; fixed for AES-128, other values unsupported.
KIDX_W, 4, width of key_idx; must hold NUM_ROUNDS.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  data_in holds a block to decrypt.
in_ready  output  1  core can accept a block this cycle.
data_in  input  129  [127:0] ciphertext, [128] tag bit passed through.
key_idx  output  KIDX_W  index of the round key needed this cycle; combinational from state.
round_key  input  128  round key for key_idx, valid in the same cycle (combinational lookup).
out_valid  output  1  data_out holds a finished plaintext block.
out_ready  input  1  consumer accepts data_out this cycle.
data_out  output  129  [127:0] plaintext, [128] tag of the originating block.
busy  output  1  high in ROUND and FINAL.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, round counter=NUM_ROUNDS-1, data register=0.
  - out_valid=0, busy=0, data_out=0, in_ready=1, key_idx=10.
- States: IDLE, ROUND, FINAL, DONE.
- key_idx:
  - IDLE and DONE: 10.
  - ROUND: counter value (9 down to 1).
  - FINAL: 0.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept = in_valid & in_ready:
  - data register[127:0] <= data_in[127:0] XOR round_key (rk10).
  - data register[128] <= data_in[128].
  - counter <= 9; next state ROUND.
- ROUND, one inverse round per cycle, in order:
  - InvShiftRows, InvSubBytes, XOR round_key (rk[counter]), InvMixColumns.
  - Result written back to the data register; counter decrements.
  - When counter==1, next state is FINAL.
- FINAL:
  - InvShiftRows, InvSubBytes, XOR rk0; no InvMixColumns.
  - Next state DONE.
- DONE:
  - out_valid=1; data_out=data register, held stable until out_ready.
  - out_ready & in_valid: output handshake and new accept in the same cycle; next state ROUND (back-to-back).
  - out_ready & !in_valid: next state IDLE.
  - !out_ready: stay in DONE (backpressure). data_out and tag must not change.
- Latency: accept edge, then 9 ROUND edges, then 1 FINAL edge. out_valid rises after the 10th edge following the accept edge.
- Throughput: one block per 11 cycles with back-to-back traffic.
- Tag bit [128] is never modified.
- in_valid outside IDLE/DONE is ignored; no accept.
- rst mid-operation: in-flight block discarded, all outputs return to reset values immediately.
- data_out reads 0 except in DONE; register contents are gated by out_valid.

Decomposition:
- Shared package aes_pkg:
  - block_t (129-bit), state_t (128-bit), kidx_t.
  - AES_ROUNDS=10 and TAG_BIT=128.
  - FSM enum {IDLE, ROUND, FINAL, DONE}.
  - Inverse S-box constant table.
- Sub-module decryptionRound: combinational inverse round with ports key, data (128), last (skips InvMixColumns), result.
  - Built from inverse S-box, inverse shift-rows and inverse mix-columns leaf blocks.
  - The core instantiates it once and feeds it back every cycle.

Test Plan:
- FIPS-197 C.1 vector:
  - Bench key ROM: rk0=000102030405060708090a0b0c0d0e0f, rk10=13111d7fe3944a17f307a78b4d2b30c5.
  - Stimulus: data_in={1'b1, 69c4e0d86a7b0430d8cdb78070b4c55a}.
  - Required: data_out={1'b1, 00112233445566778899aabbccddeeff}, out_valid 10 cycles after accept.
  - Required: key_idx sequence 10,9,...,1,0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid.
  - Required: data_out stable, in_ready=0, busy=0, a new in_valid is not accepted; release accepts exactly once.
- Back-to-back:
  - Stimulus: second block with tag 0 presented while DONE & out_ready.
  - Required: accepted in the same cycle; the second result follows 11 cycles after the first out_valid; tags stay matched to their blocks.
- Reset mid-run:
  - Stimulus: assert rst during ROUND with counter=5.
  - Required: out_valid=0, in_ready=1, key_idx=10, data_out=0 immediately. A following block decrypts correctly.
- Idle noise:
  - Stimulus: random round_key while IDLE with in_valid=0.
  - Required: no state change, out_valid stays 0.
- Random regression:
  - Stimulus: 200 random keys and blocks.
  - Required: data_out matches the reference model's inverse cipher, and encrypting through the encryption round chain returns the original ciphertext.
